mem_responder: RTL and testbench

Memory-side responder for the single-channel `mem_req`/`mem_write`/`mem_addr`/`mem_wdata`/`mem_rdata_vld`/`mem_rdata` interface driven by the matmul engine and other initiators in the design.

- Accepts one request per cycle, never stalls.
- Stores data in an internal word-addressed array.
- Returns read data after a fixed, parameterised latency.
- Flags out-of-window accesses and keeps saturating activity counters for bring-up and simulation.

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for a single-channel request interface. Accepts one
//   request per cycle with no back-pressure, stores writes in a word-addressed
//   array, and returns read data through a fixed-latency valid/err/data shift
//   register. Accesses outside the served window are flagged and counted.
//
// Ports
//   clk, rst_n      clock (rising edge) / async active-low reset
//   mem_req         request valid this cycle
//   mem_write       1 = write, 0 = read (qualified by mem_req)
//   mem_addr        word address (qualified by mem_req)
//   mem_wdata       write data (qualified by mem_req & mem_write)
//   mem_rdata_vld   one-cycle pulse per read response
//   mem_rdata       read data, 0 whenever mem_rdata_vld = 0
//   mem_err         pulse aligned with the response of an out-of-window access
//   clr_cnt         synchronous clear of all counters (wins over increments)
//   rd_cnt/wr_cnt/err_cnt  saturating 16-bit activity counters
//
// RD_LAT is legal in 1..4.
module mem_responder #(
    parameter int                MEM_AW    = 16,
    parameter int                MEM_DW    = 32,
    parameter int                DEPTH_AW  = 10,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    output logic              mem_err,
    input  logic              clr_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       err_cnt
);

    localparam int STAGES = RD_LAT - 1;
    // Window size carried one bit wider than the address so 2^DEPTH_AW is
    // representable even when it equals 2^MEM_AW.
    localparam logic [MEM_AW:0] WIN_SIZE = {{MEM_AW{1'b0}}, 1'b1} << DEPTH_AW;

    // ---------------- decode ----------------
    logic [MEM_AW-1:0]   off;
    logic [DEPTH_AW-1:0] idx;
    logic                in_win;
    logic                rd_any, rd_ok, wr_ok, wr_oow, oow;

    assign off    = mem_addr - BASE_ADDR;
    assign idx    = off[DEPTH_AW-1:0];
    assign in_win = (mem_addr >= BASE_ADDR) && ({1'b0, off} < WIN_SIZE);

    assign rd_any = mem_req & ~mem_write;
    assign rd_ok  = rd_any & in_win;
    assign wr_ok  = mem_req & mem_write & in_win;
    assign wr_oow = mem_req & mem_write & ~in_win;
    assign oow    = mem_req & ~in_win;

    // ---------------- storage ----------------
    // Not reset: contents survive rst_n and are undefined until written.
    logic [MEM_DW-1:0] mem [0:(1<<DEPTH_AW)-1];

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[idx] <= mem_wdata;
    end

    // ---------------- response pipeline ----------------
    // Stage 0 captures the array at the sampling edge; one request per cycle
    // means a read never coincides with a write, so read-after-write needs
    // no bypass. Out-of-window reads ride along with data 0 and err set.
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0]             err_pipe;
    logic [STAGES:0][MEM_DW-1:0] data_pipe;
    logic                        wr_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            err_pipe  <= '0;
            data_pipe <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            vld_pipe[0]  <= rd_any;
            err_pipe[0]  <= rd_any & ~in_win;
            data_pipe[0] <= rd_ok ? mem[idx] : '0;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                err_pipe[s]  <= err_pipe[s-1];
                data_pipe[s] <= data_pipe[s-1];
            end
            // Write errors have no data response, so they report one cycle
            // after sampling regardless of RD_LAT.
            wr_err_q <= wr_oow;
        end
    end

    assign mem_rdata_vld = vld_pipe[STAGES];
    assign mem_rdata     = vld_pipe[STAGES] ? data_pipe[STAGES] : '0;
    assign mem_err       = (vld_pipe[STAGES] & err_pipe[STAGES]) | wr_err_q;

    // ---------------- counters ----------------
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (clr_cnt) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (rd_ok) rd_cnt  <= sat_inc(rd_cnt);
            if (wr_ok) wr_cnt  <= sat_inc(wr_cnt);
            if (oow)   err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Four instances with different parameter sets
// share one clock: A (RD_LAT=1, base 0, 1K words), B (RD_LAT=3, base 0x100,
// 16 words), C (RD_LAT=2), D (RD_LAT=4). Inputs change and outputs are
// sampled on the falling edge.
module tb_mem_responder;

    logic              clk;
    logic [3:0]        rst_n, req, wr, clr;
    logic [3:0][15:0]  addr;
    logic [3:0][31:0]  wdata;
    logic [3:0]        vld, err;
    logic [3:0][31:0]  rdata;
    logic [3:0][15:0]  rdc, wrc, erc;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder u_a (
        .clk(clk), .rst_n(rst_n[0]), .mem_req(req[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata_vld(vld[0]),
        .mem_rdata(rdata[0]), .mem_err(err[0]), .clr_cnt(clr[0]),
        .rd_cnt(rdc[0]), .wr_cnt(wrc[0]), .err_cnt(erc[0]));

    mem_responder #(.DEPTH_AW(4), .BASE_ADDR(16'h0100), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .mem_req(req[1]), .mem_write(wr[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata_vld(vld[1]),
        .mem_rdata(rdata[1]), .mem_err(err[1]), .clr_cnt(clr[1]),
        .rd_cnt(rdc[1]), .wr_cnt(wrc[1]), .err_cnt(erc[1]));

    mem_responder #(.RD_LAT(2)) u_c (
        .clk(clk), .rst_n(rst_n[2]), .mem_req(req[2]), .mem_write(wr[2]),
        .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_rdata_vld(vld[2]),
        .mem_rdata(rdata[2]), .mem_err(err[2]), .clr_cnt(clr[2]),
        .rd_cnt(rdc[2]), .wr_cnt(wrc[2]), .err_cnt(erc[2]));

    mem_responder #(.RD_LAT(4)) u_d (
        .clk(clk), .rst_n(rst_n[3]), .mem_req(req[3]), .mem_write(wr[3]),
        .mem_addr(addr[3]), .mem_wdata(wdata[3]), .mem_rdata_vld(vld[3]),
        .mem_rdata(rdata[3]), .mem_err(err[3]), .clr_cnt(clr[3]),
        .rd_cnt(rdc[3]), .wr_cnt(wrc[3]), .err_cnt(erc[3]));

    typedef struct {
        bit          req;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          vld;
        logic [31:0] rdata;
        bit          err;
        logic [15:0] rc;
        logic [15:0] wc;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_req(input int u, input bit r, input bit w,
                           input logic [15:0] a, input logic [31:0] d);
        req[u]   = r;
        wr[u]    = w;
        addr[u]  = a;
        wdata[u] = d;
    endtask

    task automatic txn(input int u, input bit r, input bit w,
                       input logic [15:0] a, input logic [31:0] d);
        set_req(u, r, w, a, d);
        step();
    endtask

    task automatic chk_out(input string nm, input int u, input bit ev,
                           input logic [31:0] ed, input bit ee);
        chk({nm, " vld"},   {31'd0, vld[u]}, {31'd0, ev});
        chk({nm, " rdata"}, rdata[u], ed);
        chk({nm, " err"},   {31'd0, err[u]}, {31'd0, ee});
    endtask

    task automatic chk_cnt(input string nm, input int u, input logic [15:0] er,
                           input logic [15:0] ew, input logic [15:0] ee);
        chk({nm, " rd_cnt"},  {16'd0, rdc[u]}, {16'd0, er});
        chk({nm, " wr_cnt"},  {16'd0, wrc[u]}, {16'd0, ew});
        chk({nm, " err_cnt"}, {16'd0, erc[u]}, {16'd0, ee});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // fields: req wr addr wdata | vld rdata err | rd_cnt wr_cnt err_cnt
        vecs[0]  = '{1'b1, 1'b1, 16'd5,      32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 16'd0, 16'd1, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 16'd5,      32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 16'd1, 16'd1, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'd1023,   32'h1234,     1'b0, 32'h0,        1'b0, 16'd1, 16'd2, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'd1023,   32'h0,        1'b1, 32'h1234,     1'b0, 16'd2, 16'd2, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 16'd1024,   32'h0,        1'b1, 32'h0,        1'b1, 16'd2, 16'd2, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 16'd1024,   32'h5555,     1'b0, 32'h0,        1'b1, 16'd2, 16'd2, 16'd2};
        vecs[6]  = '{1'b0, 1'b1, 16'd5,      32'h0BAD,     1'b0, 32'h0,        1'b0, 16'd2, 16'd2, 16'd2};
        vecs[7]  = '{1'b1, 1'b0, 16'd5,      32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 16'd3, 16'd2, 16'd2};
        vecs[8]  = '{1'b1, 1'b1, 16'd0,      32'hA5A5A5A5, 1'b0, 32'h0,        1'b0, 16'd3, 16'd3, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 16'd0,      32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 16'd4, 16'd3, 16'd2};
        vecs[10] = '{1'b1, 1'b0, 16'hFFFF,   32'h0,        1'b1, 32'h0,        1'b1, 16'd4, 16'd3, 16'd3};

        rst_n = '0; req = '0; wr = '0; clr = '0; addr = '0; wdata = '0;
        repeat (3) step();
        rst_n = '1;

        // ---- reset state, all instances ----
        for (int u = 0; u < 4; u++) begin
            chk_out($sformatf("reset u%0d", u), u, 1'b0, 32'h0, 1'b0);
            chk_cnt($sformatf("reset u%0d", u), u, 16'd0, 16'd0, 16'd0);
        end

        // ---- A: table-driven, RD_LAT=1 so each row sees its own response ----
        for (int i = 0; i < 11; i++) begin
            txn(0, vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk_out($sformatf("A vec%0d", i), 0, vecs[i].vld, vecs[i].rdata, vecs[i].err);
            chk_cnt($sformatf("A vec%0d", i), 0, vecs[i].rc, vecs[i].wc, vecs[i].ec);
        end
        txn(0, 1'b0, 1'b0, 16'd0, 32'd0);
        chk_out("A idle", 0, 1'b0, 32'h0, 1'b0);

        // ---- B: RD_LAT=3 burst, base 0x100 ----
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 1'b1, 16'h0100 + 16'(i), 32'd10 + 32'(i));
            chk_out($sformatf("B wr%0d", i), 1, 1'b0, 32'h0, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < 4) set_req(1, 1'b1, 1'b0, 16'h0100 + 16'(k), 32'd0);
            else       set_req(1, 1'b0, 1'b0, 16'd0, 32'd0);
            step();
            if (k >= 2 && k <= 5)
                chk_out($sformatf("B burst%0d", k), 1, 1'b1, 32'd10 + 32'(k - 2), 1'b0);
            else
                chk_out($sformatf("B burst%0d", k), 1, 1'b0, 32'h0, 1'b0);
        end
        // out-of-window reads just below and just above the window
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      set_req(1, 1'b1, 1'b0, 16'h00FF, 32'd0);
            else if (k == 1) set_req(1, 1'b1, 1'b0, 16'h0110, 32'd0);
            else             set_req(1, 1'b0, 1'b0, 16'd0, 32'd0);
            step();
            chk_out($sformatf("B oow_rd%0d", k), 1, (k == 2 || k == 3), 32'h0, (k == 2 || k == 3));
        end
        chk_cnt("B after oow rd", 1, 16'd4, 16'd4, 16'd2);
        txn(1, 1'b1, 1'b1, 16'h0110, 32'h7777);
        chk_out("B oow_wr", 1, 1'b0, 32'h0, 1'b1);
        txn(1, 1'b0, 1'b0, 16'd0, 32'd0);
        chk_out("B oow_wr after", 1, 1'b0, 32'h0, 1'b0);
        chk_cnt("B after oow wr", 1, 16'd4, 16'd4, 16'd3);
        // top word of the window
        txn(1, 1'b1, 1'b1, 16'h010F, 32'hF0F0);
        txn(1, 1'b1, 1'b0, 16'h010F, 32'd0);
        chk_out("B top rd0", 1, 1'b0, 32'h0, 1'b0);
        txn(1, 1'b0, 1'b0, 16'd0, 32'd0);
        chk_out("B top rd1", 1, 1'b0, 32'h0, 1'b0);
        step();
        chk_out("B top rd2", 1, 1'b1, 32'hF0F0, 1'b0);
        chk_cnt("B final", 1, 16'd5, 16'd5, 16'd3);

        // ---- C: RD_LAT=2 read-after-write and write behind an in-flight read ----
        txn(2, 1'b1, 1'b1, 16'd7, 32'd1);
        txn(2, 1'b1, 1'b0, 16'd7, 32'd0);
        chk_out("C raw0", 2, 1'b0, 32'h0, 1'b0);
        txn(2, 1'b1, 1'b1, 16'd7, 32'd2);
        chk_out("C raw old", 2, 1'b1, 32'd1, 1'b0);
        txn(2, 1'b1, 1'b0, 16'd7, 32'd0);
        chk_out("C raw gap", 2, 1'b0, 32'h0, 1'b0);
        txn(2, 1'b0, 1'b0, 16'd0, 32'd0);
        chk_out("C raw new", 2, 1'b1, 32'd2, 1'b0);
        chk_cnt("C final", 2, 16'd2, 16'd2, 16'd0);

        // ---- D: RD_LAT=4, reset with reads in flight ----
        txn(3, 1'b1, 1'b1, 16'd3, 32'h33);
        txn(3, 1'b1, 1'b1, 16'd4, 32'h44);
        for (int k = 0; k < 3; k++) begin
            txn(3, 1'b1, 1'b0, 16'd3, 32'd0);
            chk_out($sformatf("D infl%0d", k), 3, 1'b0, 32'h0, 1'b0);
        end
        set_req(3, 1'b0, 1'b0, 16'd0, 32'd0);
        rst_n[3] = 1'b0;
        step();
        chk_out("D in rst", 3, 1'b0, 32'h0, 1'b0);
        rst_n[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out($sformatf("D post rst%0d", k), 3, 1'b0, 32'h0, 1'b0);
        end
        chk_cnt("D post rst", 3, 16'd0, 16'd0, 16'd0);
        txn(3, 1'b1, 1'b0, 16'd4, 32'd0);
        txn(3, 1'b1, 1'b0, 16'd3, 32'd0);
        txn(3, 1'b0, 1'b0, 16'd0, 32'd0);
        step();
        chk_out("D keep 4", 3, 1'b1, 32'h44, 1'b0);
        step();
        chk_out("D keep 3", 3, 1'b1, 32'h33, 1'b0);
        step();
        chk_out("D drained", 3, 1'b0, 32'h0, 1'b0);

        // ---- A: wr_cnt saturation, then clear racing a write ----
        for (int i = 0; i < 65536; i++)
            txn(0, 1'b1, 1'b1, 16'd1, 32'(i));
        chk_cnt("A sat", 0, 16'd4, 16'hFFFF, 16'd3);
        txn(0, 1'b1, 1'b1, 16'd1, 32'd0);
        chk_cnt("A sat hold", 0, 16'd4, 16'hFFFF, 16'd3);
        clr[0] = 1'b1;
        txn(0, 1'b1, 1'b1, 16'd2, 32'd9);
        clr[0] = 1'b0;
        chk_cnt("A clr", 0, 16'd0, 16'd0, 16'd0);
        txn(0, 1'b1, 1'b0, 16'd2, 32'd0);
        chk_out("A clr wr kept", 0, 1'b1, 32'd9, 1'b0);
        chk_cnt("A after clr", 0, 16'd1, 16'd0, 16'd0);
        txn(0, 1'b0, 1'b0, 16'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
